// File: rtl/sys_ctrl_gen2_if.sv
// sys_ctrl_gen2_if: bundles the byte, register-file, ALU and transmitter
// signals of the system controller. The master modport is the controller
// side and the slave modport is the environment (RX sync, RF, ALU, TX sync).
interface sys_ctrl_gen2_if #(
  parameter int ADDR_WIDTH   = 4,
  parameter int RESULT_WIDTH = 16
);
  logic [7:0]              RX_P_DATA;
  logic                    RX_D_Valid;
  logic [ADDR_WIDTH-1:0]   RF_Addr;
  logic                    RF_WrEn;
  logic                    RF_RdEn;
  logic [7:0]              RF_WrData;
  logic [7:0]              RF_RdData;
  logic                    RF_RdData_Valid;
  logic [3:0]              ALU_FUN;
  logic                    ALU_EN;
  logic                    CLK_GATE_EN;
  logic [RESULT_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_Valid;
  logic [7:0]              TX_P_DATA;
  logic                    TX_D_Valid;
  logic                    TX_Busy;
  logic                    Err_Frame;
  logic                    Err_Timeout;

  modport master (
    input  RX_P_DATA, RX_D_Valid, RF_RdData, RF_RdData_Valid,
           ALU_OUT, ALU_OUT_Valid, TX_Busy,
    output RF_Addr, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN,
           CLK_GATE_EN, TX_P_DATA, TX_D_Valid, Err_Frame, Err_Timeout
  );

  modport slave (
    output RX_P_DATA, RX_D_Valid, RF_RdData, RF_RdData_Valid,
           ALU_OUT, ALU_OUT_Valid, TX_Busy,
    input  RF_Addr, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN,
           CLK_GATE_EN, TX_P_DATA, TX_D_Valid, Err_Frame, Err_Timeout
  );
endinterface

// File: rtl/sys_ctrl_gen2.sv
// sys_ctrl_gen2: second-generation UART command controller (REF_CLK domain).
// Parses 0xAA/0xBB/0xCC/0xDD frames, drives register-file and ALU strobes,
// and sends results back LS byte first. All outputs come straight from flops.
// Optional inter-byte timeout: define CMD_TIMEOUT_EN.
//
// TX handshake: TX_D_Valid is a level request raised only while TX_Busy=0,
// with TX_P_DATA stable while it is high. The transmitter accepts the byte by
// raising TX_Busy; the controller then drops TX_D_Valid and moves to the next
// byte, which waits until TX_Busy returns to 0.
module sys_ctrl_gen2 #(
  parameter int ADDR_WIDTH     = 4,
  parameter int RESULT_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  sys_ctrl_gen2_if.master       bus,
  output logic [3:0]            state_dbg
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] OPA      = 4'd5;
  localparam logic [3:0] OPB      = 4'd6;
  localparam logic [3:0] FUN      = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX_SEND  = 4'd9;

  localparam int NB    = RESULT_WIDTH / 8;
  localparam int IDX_W = $clog2(NB) + 1;

  logic [3:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic                    rf_wren_q, rf_wren_d;
  logic                    rf_rden_q, rf_rden_d;
  logic [7:0]              rf_wrdata_q, rf_wrdata_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    alu_en_q, alu_en_d;
  logic                    gate_q, gate_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    err_frame_q, err_frame_d;
  logic [RESULT_WIDTH-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [RESULT_WIDTH-1:0] buf_shift;
  logic                    last_byte;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  // The timeout fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_to_q, err_to_d;
  logic            timed;
`endif

  // Byte currently selected for transmission (LS byte at index 0)
  always_comb begin
    buf_shift = buf_q >> {idx_q, 3'b000};
    last_byte = ((idx_q + IDX_W'(1)) == cnt_q);
  end

  // Next-state and output-register computation for the command FSM
  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    rf_wren_d   = 1'b0;
    rf_rden_d   = 1'b0;
    rf_wrdata_d = rf_wrdata_q;
    alu_fun_d   = alu_fun_q;
    alu_en_d    = 1'b0;
    gate_d      = gate_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    err_frame_d = 1'b0;
    buf_d       = buf_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.RX_D_Valid) begin
          case (bus.RX_P_DATA)
            8'hAA:   state_d = WR_ADDR;
            8'hBB:   state_d = RD_ADDR;
            8'hCC:   state_d = OPA;
            8'hDD:   state_d = FUN;
            default: err_frame_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_Valid) begin
          rf_addr_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.RX_D_Valid) begin
          rf_wren_d   = 1'b1;
          rf_wrdata_d = bus.RX_P_DATA;
          state_d     = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_Valid) begin
          rf_addr_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rden_d = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // A byte arriving here is dropped, but a same-cycle capture still happens
        if (bus.RX_D_Valid) err_frame_d = 1'b1;
        if (bus.RF_RdData_Valid) begin
          buf_d   = RESULT_WIDTH'(bus.RF_RdData);
          cnt_d   = IDX_W'(1);
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      OPA: begin
        if (bus.RX_D_Valid) begin
          rf_addr_d   = '0;
          rf_wren_d   = 1'b1;
          rf_wrdata_d = bus.RX_P_DATA;
          state_d     = OPB;
        end
      end
      OPB: begin
        if (bus.RX_D_Valid) begin
          rf_addr_d   = ADDR_WIDTH'(1);
          rf_wren_d   = 1'b1;
          rf_wrdata_d = bus.RX_P_DATA;
          state_d     = FUN;
        end
      end
      FUN: begin
        if (bus.RX_D_Valid) begin
          alu_fun_d = bus.RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          gate_d    = 1'b1;
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (bus.RX_D_Valid) err_frame_d = 1'b1;
        if (bus.ALU_OUT_Valid) begin
          buf_d   = bus.ALU_OUT;
          gate_d  = 1'b0;
          cnt_d   = IDX_W'(NB);
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (bus.RX_D_Valid) err_frame_d = 1'b1;
        if (!tx_valid_q) begin
          if (!bus.TX_Busy) begin
            tx_valid_d = 1'b1;
            tx_data_d  = buf_shift[7:0];
          end
        end else if (bus.TX_Busy) begin
          tx_valid_d = 1'b0;
          if (last_byte) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef CMD_TIMEOUT_EN
    timed = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
            (state_q == OPA) || (state_q == OPB) || (state_q == FUN);
    err_to_d = 1'b0;
    // No byte arrived in a timed state, so no strobe was raised above
    if (timed && !bus.RX_D_Valid && (to_cnt_q == TO_LAST)) begin
      state_d  = IDLE;
      err_to_d = 1'b1;
    end
    if (!timed || bus.RX_D_Valid || (state_d != state_q)) to_cnt_d = '0;
    else                                                   to_cnt_d = to_cnt_q + TO_W'(1);
`endif
  end

  // State and registered outputs; reset clears everything asynchronously
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      rf_addr_q   <= '0;
      rf_wren_q   <= 1'b0;
      rf_rden_q   <= 1'b0;
      rf_wrdata_q <= '0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      gate_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      err_frame_q <= 1'b0;
      buf_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      rf_wren_q   <= rf_wren_d;
      rf_rden_q   <= rf_rden_d;
      rf_wrdata_q <= rf_wrdata_d;
      alu_fun_q   <= alu_fun_d;
      alu_en_q    <= alu_en_d;
      gate_q      <= gate_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      err_frame_q <= err_frame_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  // Inter-byte timeout counter and its error pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end
  assign bus.Err_Timeout = err_to_q;
`else
  assign bus.Err_Timeout = 1'b0;
`endif

  assign bus.RF_Addr     = rf_addr_q;
  assign bus.RF_WrEn     = rf_wren_q;
  assign bus.RF_RdEn     = rf_rden_q;
  assign bus.RF_WrData   = rf_wrdata_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.CLK_GATE_EN = gate_q;
  assign bus.TX_P_DATA   = tx_data_q;
  assign bus.TX_D_Valid  = tx_valid_q;
  assign bus.Err_Frame   = err_frame_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// tb_sys_ctrl_gen2: directed bench for sys_ctrl_gen2 (ADDR_WIDTH=4,
// RESULT_WIDTH=16, TIMEOUT_CYCLES=16). Timeout steps run when CMD_TIMEOUT_EN
// is defined. RF read data, ALU results and the transmitter are emulated by
// small responder processes.
module tb_sys_ctrl_gen2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state_dbg;
  always #5 clk = ~clk;

  sys_ctrl_gen2_if #(.ADDR_WIDTH(4), .RESULT_WIDTH(16)) bus ();

  sys_ctrl_gen2 #(.ADDR_WIDTH(4), .RESULT_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];      // expected TX bytes in order
  logic [15:0] exp_wr_q[$];   // expected RF writes {addr, data}
  logic [3:0]  exp_fun = '0;
  logic [3:0]  exp_rd_addr = '0;
  logic [7:0]  rd_value = '0;
  logic [15:0] alu_value = '0;
  logic        tx_auto = 1'b1;
  logic        busy_auto = 1'b0;
  int          n_wren = 0, n_rden = 0, n_alu_en = 0, n_err_frame = 0, n_err_to = 0;

  assign bus.TX_Busy = busy_auto;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- strobe monitor ----------------
  always @(negedge clk) begin
    if (bus.RF_WrEn) begin
      n_wren++;
      if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        logic [15:0] e;
        e = exp_wr_q.pop_front();
        chk("wr_addr", 32'(bus.RF_Addr), 32'(e[15:8]));
        chk("wr_data", 32'(bus.RF_WrData), 32'(e[7:0]));
      end
    end
    if (bus.RF_RdEn) begin
      n_rden++;
      chk("rd_addr", 32'(bus.RF_Addr), 32'(exp_rd_addr));
    end
    if (bus.ALU_EN) begin
      n_alu_en++;
      chk("alu_fun", 32'(bus.ALU_FUN), 32'(exp_fun));
      chk("gate_with_en", 32'(bus.CLK_GATE_EN), 32'd1);
    end
    if (bus.Err_Frame)   n_err_frame++;
    if (bus.Err_Timeout) n_err_to++;
  end

  // ---------------- responders ----------------
  initial begin
    bus.RF_RdData = '0;
    bus.RF_RdData_Valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.RF_RdEn) begin
        repeat (2) @(negedge clk);
        bus.RF_RdData = rd_value;
        bus.RF_RdData_Valid = 1'b1;
        @(negedge clk);
        bus.RF_RdData_Valid = 1'b0;
      end
    end
  end

  initial begin
    bus.ALU_OUT = '0;
    bus.ALU_OUT_Valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ALU_EN) begin
        repeat (6) @(negedge clk);
        chk("gate_during_wait", 32'(bus.CLK_GATE_EN), 32'd1);
        bus.ALU_OUT = alu_value;
        bus.ALU_OUT_Valid = 1'b1;
        @(negedge clk);
        bus.ALU_OUT_Valid = 1'b0;
        chk("gate_after_valid", 32'(bus.CLK_GATE_EN), 32'd0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_auto && bus.TX_D_Valid) begin
        logic [7:0] b;
        b = bus.TX_P_DATA;
        if (exp_q.size() == 0) chk("tx_unexpected", 32'(b), 32'hFFFF);
        else                   chk("tx_byte", 32'(b), 32'(exp_q.pop_front()));
        repeat (2) begin
          @(negedge clk);
          chk("tx_hold_valid", 32'(bus.TX_D_Valid), 32'd1);
          chk("tx_hold_data", 32'(bus.TX_P_DATA), 32'(b));
        end
        busy_auto = 1'b1;
        @(negedge clk);
        chk("tx_drop", 32'(bus.TX_D_Valid), 32'd0);
        repeat (3) @(negedge clk);
        busy_auto = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.RX_P_DATA = b;
    bus.RX_D_Valid = 1'b1;
    @(posedge clk); #1;
    bus.RX_D_Valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state_dbg == 4'd0 && exp_q.size() == 0 && !busy_auto && !bus.TX_D_Valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s_wr, s_rd, s_alu, s_ef;
    logic seen;
    bus.RX_P_DATA = '0;
    bus.RX_D_Valid = 1'b0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_wren",  32'(bus.RF_WrEn), 0);
    chk("rst_rden",  32'(bus.RF_RdEn), 0);
    chk("rst_alu_en", 32'(bus.ALU_EN), 0);
    chk("rst_gate",  32'(bus.CLK_GATE_EN), 0);
    chk("rst_txv",   32'(bus.TX_D_Valid), 0);
    chk("rst_txd",   32'(bus.TX_P_DATA), 0);
    chk("rst_addr",  32'(bus.RF_Addr), 0);
    chk("rst_errf",  32'(bus.Err_Frame), 0);
    chk("rst_errt",  32'(bus.Err_Timeout), 0);
    chk("rst_state", 32'(state_dbg), 0);
    @(negedge clk) rst_n = 1'b1;

    // RF write 0xAA 0x05 0x3C
    s_wr = n_wren;
    exp_wr_q.push_back(16'h053C);
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    repeat (3) @(negedge clk);
    chk("wr_count", 32'(n_wren - s_wr), 1);
    chk("wr_state_idle", 32'(state_dbg), 0);
    chk("wr_addr_held", 32'(bus.RF_Addr), 5);

    // RF read 0xBB 0x02 -> 0x81
    s_rd = n_rden;
    exp_rd_addr = 4'd2;
    rd_value = 8'h81;
    exp_q.push_back(8'h81);
    send_byte(8'hBB); send_byte(8'h02);
    wait_done("rd_done");
    chk("rd_count", 32'(n_rden - s_rd), 1);

    // 0xCC 0x12 0x34 0x02 with result 0x03A8
    s_wr = n_wren; s_alu = n_alu_en;
    exp_wr_q.push_back(16'h0012);
    exp_wr_q.push_back(16'h0134);
    exp_fun = 4'd2;
    alu_value = 16'h03A8;
    exp_q.push_back(8'hA8); exp_q.push_back(8'h03);
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
    wait_done("cc_done");
    chk("cc_wr_count", 32'(n_wren - s_wr), 2);
    chk("cc_alu_count", 32'(n_alu_en - s_alu), 1);
    chk("cc_gate_low", 32'(bus.CLK_GATE_EN), 0);
    chk("cc_wr_all", 32'(exp_wr_q.size()), 0);

    // Illegal byte in IDLE
    s_wr = n_wren; s_rd = n_rden; s_alu = n_alu_en; s_ef = n_err_frame;
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    chk("ill_err", 32'(n_err_frame - s_ef), 1);
    chk("ill_no_wr", 32'(n_wren - s_wr), 0);
    chk("ill_no_rd", 32'(n_rden - s_rd), 0);
    chk("ill_no_alu", 32'(n_alu_en - s_alu), 0);
    chk("ill_state", 32'(state_dbg), 0);

    // 0xDD 0xF5 (high nibble ignored), byte injected during ALU_WAIT
    s_alu = n_alu_en; s_ef = n_err_frame;
    exp_fun = 4'd5;
    alu_value = 16'hBEEF;
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    send_byte(8'hDD); send_byte(8'hF5); send_byte(8'h77);
    wait_done("inj_done");
    chk("inj_err", 32'(n_err_frame - s_ef), 1);
    chk("inj_alu_count", 32'(n_alu_en - s_alu), 1);

`ifdef CMD_TIMEOUT_EN
    // Timeout: 0xAA 0x01 then silence
    begin
      logic early;
      s_wr = n_wren;
      early = 1'b0;
      send_byte(8'hAA); send_byte(8'h01);
      for (int k = 1; k <= 14; k++) begin
        @(posedge clk); #1;
        if (bus.Err_Timeout) early = 1'b1;
      end
      chk("to_not_early", 32'(early), 0);
      @(posedge clk); #1;
      chk("to_pulse", 32'(bus.Err_Timeout), 1);
      chk("to_idle", 32'(state_dbg), 0);
      @(posedge clk); #1;
      chk("to_one_cycle", 32'(bus.Err_Timeout), 0);
      chk("to_no_wr", 32'(n_wren - s_wr), 0);
      exp_wr_q.push_back(16'h017F);
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7F);
      repeat (3) @(negedge clk);
      chk("to_after_wr", 32'(n_wren - s_wr), 1);
      chk("to_after_state", 32'(state_dbg), 0);
    end
`else
    // Without the timeout option a partial frame just waits
    send_byte(8'hAA); send_byte(8'h01);
    repeat (40) @(negedge clk);
    chk("nto_waiting", 32'(state_dbg), 2);
    chk("nto_no_err", 32'(n_err_to), 0);
    s_wr = n_wren;
    exp_wr_q.push_back(16'h017F);
    send_byte(8'h7F);
    repeat (3) @(negedge clk);
    chk("nto_wr", 32'(n_wren - s_wr), 1);
`endif

    // Reset while byte 0 is on offer
    tx_auto = 1'b0;
    exp_fun = 4'd0;
    alu_value = 16'h1234;
    send_byte(8'hDD); send_byte(8'h00);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.TX_D_Valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_tx_seen", 32'(seen), 1);
    chk("rst_tx_byte0", 32'(bus.TX_P_DATA), 32'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_drop", 32'(bus.TX_D_Valid), 0);
    chk("rst_tx_state", 32'(state_dbg), 0);
    chk("rst_tx_data", 32'(bus.TX_P_DATA), 0);
    @(negedge clk) rst_n = 1'b1;
    tx_auto = 1'b1;

    // 0xDD 0x00 after reset
    s_alu = n_alu_en;
    alu_value = 16'h00F0;
    exp_q.push_back(8'hF0); exp_q.push_back(8'h00);
    send_byte(8'hDD); send_byte(8'h00);
    wait_done("post_rst_done");
    chk("post_rst_alu", 32'(n_alu_en - s_alu), 1);
    chk("final_wr_all", 32'(exp_wr_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
